// File: rtl/gpio_sram_scan_ctrl.sv
// Chip-side responder for the GPIO SRAM scan protocol: a serial frame register, a
// one-shot issue FSM driving one of NUM_BANKS dual-port SRAM banks, and read capture.
module gpio_sram_scan_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int WMASK_W   = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        scan_in,
    input  logic                        scan_en,
    input  logic                        sram_load,
    input  logic                        global_csb,
    output logic                        scan_out,
    output logic                        busy,
    output logic                        sel_err,
    output logic [NUM_BANKS-1:0]        sram_csb0,
    output logic [NUM_BANKS-1:0]        sram_csb1,
    output logic                        sram_web0,
    output logic                        sram_web1,
    output logic [WMASK_W-1:0]          sram_wmask0,
    output logic [WMASK_W-1:0]          sram_wmask1,
    output logic [ADDR_W-1:0]           sram_addr0,
    output logic [ADDR_W-1:0]           sram_addr1,
    output logic [DATA_W-1:0]           sram_din0,
    output logic [DATA_W-1:0]           sram_din1,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_dout1
);

    localparam int PORT_W  = ADDR_W + DATA_W + 2 + WMASK_W;
    localparam int FRAME_W = 4 + 2 * PORT_W;
    localparam int CNT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  din;
        logic               csb;
        logic               web;
        logic [WMASK_W-1:0] wmask;
    } port_t;

    typedef struct packed {
        logic [3:0] sel;
        port_t      p0;
        port_t      p1;
    } frame_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    frame_t             frame_q, frame_d;
    frame_t             cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic               sel_err_q, sel_err_d;
    logic               armed_q, armed_d;
    logic               load_pend_q, load_pend_d;

    logic               frame_sel_ok;
    logic               cmd_sel_ok;
    logic [DATA_W-1:0]  dout0_sel;
    logic [DATA_W-1:0]  dout1_sel;

    assign scan_out     = frame_q[FRAME_W-1];
    assign busy         = (state_q != S_IDLE);
    assign sel_err      = sel_err_q;
    assign frame_sel_ok = (int'(frame_q.sel) < NUM_BANKS);
    assign cmd_sel_ok   = (int'(cmd_q.sel) < NUM_BANKS);

    always_comb begin
        dout0_sel = '0;
        dout1_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (cmd_q.sel == 4'(b)) begin
                dout0_sel = sram_dout0[b*DATA_W +: DATA_W];
                dout1_sel = sram_dout1[b*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: every variable gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        sel_err_d   = sel_err_q;
        armed_d     = armed_q;
        load_pend_d = load_pend_q;

        // A low strobe only re-arms after a high level; lows seen while busy are dropped.
        if (global_csb) begin
            armed_d = 1'b1;
        end else if (busy) begin
            armed_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!global_csb && !scan_en && armed_q) begin
                    cmd_d     = frame_q;
                    sel_err_d = !frame_sel_ok;
                    armed_d   = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (cmd_sel_ok && !cmd_q.p0.csb && cmd_q.p0.web) begin
                        rdata0_d = dout0_sel;
                    end
                    if (cmd_sel_ok && !cmd_q.p1.csb && cmd_q.p1.web) begin
                        rdata1_d = dout1_sel;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shifting wins over load; a load seen while busy waits for IDLE unless a shift cancels it.
        if (scan_en) begin
            frame_d     = frame_t'({frame_q[FRAME_W-2:0], scan_in});
            load_pend_d = 1'b0;
        end else if (sram_load || load_pend_q) begin
            if (busy) begin
                load_pend_d = 1'b1;
            end else begin
                load_pend_d = 1'b0;
                if (!cmd_q.p0.csb && cmd_q.p0.web) begin
                    frame_d.p0.din = rdata0_q;
                end
                if (!cmd_q.p1.csb && cmd_q.p1.web) begin
                    frame_d.p1.din = rdata1_q;
                end
            end
        end
    end

    // SRAM pins are decoded straight from state so an async reset releases them at once.
    always_comb begin
        sram_csb0   = '1;
        sram_csb1   = '1;
        sram_web0   = 1'b1;
        sram_web1   = 1'b1;
        sram_wmask0 = '0;
        sram_wmask1 = '0;
        sram_addr0  = '0;
        sram_addr1  = '0;
        sram_din0   = '0;
        sram_din1   = '0;
        if (state_q == S_ISSUE) begin
            sram_web0   = cmd_q.p0.web;
            sram_web1   = cmd_q.p1.web;
            sram_wmask0 = cmd_q.p0.wmask;
            sram_wmask1 = cmd_q.p1.wmask;
            sram_addr0  = cmd_q.p0.addr;
            sram_addr1  = cmd_q.p1.addr;
            sram_din0   = cmd_q.p0.din;
            sram_din1   = cmd_q.p1.din;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (cmd_q.sel == 4'(b)) begin
                    sram_csb0[b] = cmd_q.p0.csb;
                    sram_csb1[b] = cmd_q.p1.csb;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            sel_err_q   <= 1'b0;
            armed_q     <= 1'b0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            sel_err_q   <= sel_err_d;
            armed_q     <= armed_d;
            load_pend_q <= load_pend_d;
        end
    end

endmodule

// File: tb/tb_gpio_sram_scan_ctrl.sv
// Directed bench for gpio_sram_scan_ctrl: a table of frames issued to a behavioural
// 4-bank dual-port SRAM, plus hand sequences for busy, load and reset corner cases.
module tb_gpio_sram_scan_ctrl;

    localparam int NB = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          scan_in, scan_en, sram_load, global_csb;
    logic          scan_out, busy, sel_err;
    logic [NB-1:0] sram_csb0, sram_csb1;
    logic          sram_web0, sram_web1;
    logic [3:0]    sram_wmask0, sram_wmask1;
    logic [15:0]   sram_addr0, sram_addr1;
    logic [31:0]   sram_din0, sram_din1;
    logic [NB*DW-1:0] sram_dout0, sram_dout1;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_sram_scan_ctrl #(
        .NUM_BANKS(4), .ADDR_W(16), .DATA_W(32), .WMASK_W(4), .READ_LAT(1)
    ) dut (
        .clk(clk), .resetn(resetn), .scan_in(scan_in), .scan_en(scan_en),
        .sram_load(sram_load), .global_csb(global_csb), .scan_out(scan_out),
        .busy(busy), .sel_err(sel_err), .sram_csb0(sram_csb0), .sram_csb1(sram_csb1),
        .sram_web0(sram_web0), .sram_web1(sram_web1), .sram_wmask0(sram_wmask0),
        .sram_wmask1(sram_wmask1), .sram_addr0(sram_addr0), .sram_addr1(sram_addr1),
        .sram_din0(sram_din0), .sram_din1(sram_din1), .sram_dout0(sram_dout0),
        .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM banks: one-cycle read latency, byte-masked writes, 256 words each.
    logic [31:0] mem [NB][256];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb0[b]) begin
                if (!sram_web0) begin
                    for (int k = 0; k < 4; k++)
                        if (sram_wmask0[k]) mem[b][sram_addr0[7:0]][8*k +: 8] = sram_din0[8*k +: 8];
                end else begin
                    sram_dout0[DW*b +: DW] <= mem[b][sram_addr0[7:0]];
                end
            end
            if (!sram_csb1[b]) begin
                if (!sram_web1) begin
                    for (int k = 0; k < 4; k++)
                        if (sram_wmask1[k]) mem[b][sram_addr1[7:0]][8*k +: 8] = sram_din1[8*k +: 8];
                end else begin
                    sram_dout1[DW*b +: DW] <= mem[b][sram_addr1[7:0]];
                end
            end
        end
    end

    typedef struct {
        string        name;
        logic [111:0] frame;
        logic [3:0]   csb0;
        logic [3:0]   csb1;
        logic         err;
        logic         do_load;
        logic [111:0] exp_read;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [111:0] frm(input logic [3:0] sel,
        input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    function automatic logic [31:0] dat0(input int b);
        return 32'(b * 256 + 1);
    endfunction
    function automatic logic [31:0] dat1(input int b);
        return 32'(b * 256 + 2);
    endfunction
    function automatic logic [111:0] rd_frame(input int b);
        return frm(4'(b), 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd2, 32'd0, 1'b0, 1'b1, 4'd0);
    endfunction
    function automatic logic [111:0] rd_exp(input int b);
        return frm(4'(b), 16'd1, dat0(b), 1'b0, 1'b1, 4'd0, 16'd2, dat1(b), 1'b0, 1'b1, 4'd0);
    endfunction

    // All tasks start just after a falling edge and return just after one.
    task automatic shift_frame(input logic [111:0] din, output logic [111:0] got);
        for (int i = 111; i >= 0; i--) begin
            got[i]  = scan_out;
            scan_en = 1'b1;
            scan_in = din[i];
            @(negedge clk);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic issue(input logic [111:0] f, input logic [3:0] c0, input logic [3:0] c1,
                         input logic err, input string tag);
        int n;
        global_csb = 1'b0;
        @(negedge clk);
        global_csb = 1'b1;
        check({tag, " csb"}, {sram_csb0, sram_csb1}, {c0, c1});
        check({tag, " port0"}, {sram_addr0, sram_din0, sram_web0, sram_wmask0}, {f[107:60], f[58:54]});
        check({tag, " port1"}, {sram_addr1, sram_din1, sram_web1, sram_wmask1}, {f[53:6], f[4:0]});
        check({tag, " sel_err"}, sel_err, err);
        n = 1;
        @(negedge clk);
        check({tag, " csb_release"}, {sram_csb0, sram_csb1}, 8'hFF);
        while (busy && n < 16) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_len"}, n, 3);
    endtask

    task automatic load_pulse();
        sram_load = 1'b1;
        @(negedge clk);
        sram_load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         v;
        logic [111:0] got, f, e;
        logic [3:0]   bank_n [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        v.name = "t1_write"; v.frame = frm(4'd0, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0);
        v.csb0 = 4'b1110; v.csb1 = 4'b1111; v.err = 1'b0; v.do_load = 1'b0; v.exp_read = '0;
        vecs.push_back(v);
        for (int b = 0; b < 4; b++) begin
            v.name = $sformatf("wr_bank%0d", b);
            v.frame = frm(4'(b), 16'd1, dat0(b), 1'b0, 1'b0, 4'hF, 16'd2, dat1(b), 1'b0, 1'b0, 4'hF);
            v.csb0 = bank_n[b]; v.csb1 = bank_n[b]; v.err = 1'b0; v.do_load = 1'b0; v.exp_read = '0;
            vecs.push_back(v);
        end
        for (int b = 0; b < 4; b++) begin
            v.name = $sformatf("rd_bank%0d", b);
            v.frame = rd_frame(b); v.csb0 = bank_n[b]; v.csb1 = bank_n[b];
            v.err = 1'b0; v.do_load = 1'b1; v.exp_read = rd_exp(b);
            vecs.push_back(v);
        end
        v.name = "mask_full"; v.frame = frm(4'd0, 16'd3, 32'hAABBCCDD, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0);
        v.csb0 = 4'b1110; v.csb1 = 4'b1111; v.err = 1'b0; v.do_load = 1'b0; v.exp_read = '0;
        vecs.push_back(v);
        v.name = "mask_part"; v.frame = frm(4'd0, 16'd3, 32'h11223344, 1'b0, 1'b0, 4'b0101, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0);
        vecs.push_back(v);
        v.name = "mask_read"; v.frame = frm(4'd0, 16'd3, 32'd0, 1'b0, 1'b1, 4'd0, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0);
        v.do_load = 1'b1; v.exp_read = frm(4'd0, 16'd3, 32'hAA22CC44, 1'b0, 1'b1, 4'd0, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0);
        vecs.push_back(v);
        v.name = "wr0_rd1"; v.frame = frm(4'd1, 16'd5, 32'h77, 1'b0, 1'b0, 4'hF, 16'd2, 32'd0, 1'b0, 1'b1, 4'd0);
        v.csb0 = 4'b1101; v.csb1 = 4'b1101; v.do_load = 1'b1;
        v.exp_read = frm(4'd1, 16'd5, 32'h77, 1'b0, 1'b0, 4'hF, 16'd2, 32'h102, 1'b0, 1'b1, 4'd0);
        vecs.push_back(v);
        v.name = "sel7"; v.frame = frm(4'd7, 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd2, 32'd0, 1'b0, 1'b1, 4'd0);
        v.csb0 = 4'b1111; v.csb1 = 4'b1111; v.err = 1'b1; v.do_load = 1'b0; v.exp_read = '0;
        vecs.push_back(v);
        v.name = "sel4"; v.frame = frm(4'd4, 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd2, 32'd0, 1'b1, 1'b1, 4'd0);
        vecs.push_back(v);
        v.name = "sel_err_clear"; v.frame = rd_frame(0); v.csb0 = 4'b1110; v.csb1 = 4'b1110;
        v.err = 1'b0; v.do_load = 1'b1; v.exp_read = rd_exp(0);
        vecs.push_back(v);

        resetn = 1'b0; scan_in = 1'b0; scan_en = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset ctrl", {scan_out, busy, sel_err}, 3'b000);
        check("reset csb_web", {sram_csb0, sram_csb1, sram_web0, sram_web1}, 10'h3FF);
        check("reset sram_data", {sram_wmask0, sram_wmask1, sram_addr0, sram_addr1}, '0);
        check("reset sram_din", {sram_din0, sram_din1}, '0);
        shift_frame('0, got);
        check("reset frame", got, '0);

        foreach (vecs[i]) begin
            shift_frame(vecs[i].frame, got);
            issue(vecs[i].frame, vecs[i].csb0, vecs[i].csb1, vecs[i].err, vecs[i].name);
            if (vecs[i].do_load) begin
                load_pulse();
                shift_frame('0, got);
                check({vecs[i].name, " readback"}, got, vecs[i].exp_read);
            end
        end

        // Shift delay: a frame comes back out MSB first exactly 112 shifts later.
        f = 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654;
        e = {14{8'hA5}};
        shift_frame(f, got);
        shift_frame(e, got);
        check("shift prev_frame", got, f);
        shift_frame('0, got);
        check("shift pattern", got, e);

        // Strobe and load during WAIT: strobe dropped, load lands after DONE.
        shift_frame(rd_frame(2), got);
        global_csb = 1'b0;
        @(negedge clk);
        global_csb = 1'b1;
        @(negedge clk);
        global_csb = 1'b0;
        sram_load  = 1'b1;
        @(negedge clk);
        sram_load = 1'b0;
        @(negedge clk);
        check("busy_drop idle1", busy, 1'b0);
        @(negedge clk);
        check("busy_drop idle2", {busy, sram_csb0, sram_csb1}, 9'h0FF);
        global_csb = 1'b1;
        @(negedge clk);
        shift_frame('0, got);
        check("pending load", got, rd_exp(2));

        // Pending load cancelled by a shift before DONE.
        f = rd_frame(3);
        shift_frame(f, got);
        global_csb = 1'b0;
        @(negedge clk);
        global_csb = 1'b1;
        sram_load  = 1'b1;
        @(negedge clk);
        sram_load = 1'b0;
        scan_en   = 1'b1;
        scan_in   = 1'b0;
        @(negedge clk);
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        shift_frame('0, got);
        e = {f[110:0], 1'b0};
        check("load cancel", got, e);

        // scan_en with sram_load in the same idle cycle only shifts.
        f = rd_frame(1);
        shift_frame(f, got);
        issue(f, 4'b1101, 4'b1101, 1'b0, "rd_bank1_noload");
        scan_en = 1'b1; sram_load = 1'b1; scan_in = 1'b1;
        @(negedge clk);
        scan_en = 1'b0; sram_load = 1'b0; scan_in = 1'b0;
        repeat (2) @(negedge clk);
        shift_frame('0, got);
        e = {f[110:0], 1'b1};
        check("scan_over_load", got, e);

        // Async reset in WAIT with a load pending.
        shift_frame(rd_exp(0), got);
        global_csb = 1'b0;
        @(negedge clk);
        global_csb = 1'b1;
        sram_load  = 1'b1;
        @(negedge clk);
        sram_load = 1'b0;
        check("pre_reset busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("reset mid csb", {sram_csb0, sram_csb1}, 8'hFF);
        check("reset mid busy", {busy, sel_err, scan_out}, 3'b000);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        shift_frame('0, got);
        check("reset mid frame", got, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
